// File: rtl/cb_seq_ctrl_pkg.sv
// Shared definitions for the code-block sequencer: state encoding, block
// geometry constants and the byte-length helper used by the controller.
package cb_seq_ctrl_pkg;

    localparam int SMALL_BITS = 1056;
    localparam int LARGE_BITS = 6144;
    localparam int BYTE_SHIFT = 3;
    localparam int ADDR_W     = 13;
    localparam int BCNT_W     = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ENCODE = 3'd2,
        ST_TAIL   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Index of the final byte of a block: 131 for small, 767 for large.
    function automatic logic [BCNT_W-1:0] last_byte_of(input logic size,
                                                       input int   small_bits,
                                                       input int   large_bits);
        int bits;
        bits = size ? large_bits : small_bits;
        return BCNT_W'((bits >> BYTE_SHIFT) - 1);
    endfunction

endpackage

// File: rtl/cb_seq_ctrl_byte_step_counter.sv
// Byte-granular block counter. Produces the byte index, the matching buffer
// bit address (index * 8) and a flag when the index reaches the last byte.
module byte_step_counter
    import cb_seq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [BCNT_W-1:0] last_byte,
    output logic [BCNT_W-1:0] cnt,
    output logic [ADDR_W-1:0] addr,
    output logic              at_last
);

    logic [BCNT_W-1:0] cnt_q;
    logic [BCNT_W-1:0] cnt_d;

    // Next count: clear wins over increment, otherwise hold.
    always_comb begin
        // NOTE: default assignment first so every path assigns cnt_d; no latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + BCNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so all flops update together from pre-edge values.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign addr    = {cnt_q, {BYTE_SHIFT{1'b0}}};
    assign at_last = (cnt_q == last_byte);

endmodule

// File: rtl/cb_seq_ctrl.sv
// Code-block sequencer: loads one turbo code block into the buffer, streams
// its read addresses to the encoder, runs trellis termination, then pulses
// done. abort and reset discard the block at any point.
module cb_seq_ctrl #(
    parameter int SMALL_BITS  = cb_seq_ctrl_pkg::SMALL_BITS,
    parameter int LARGE_BITS  = cb_seq_ctrl_pkg::LARGE_BITS,
    parameter int TAIL_CYCLES = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               block_size,
    input  logic                               abort,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic                               wr_en,
    output logic [cb_seq_ctrl_pkg::ADDR_W-1:0] wr_addr,
    output logic                               rd_en,
    output logic [cb_seq_ctrl_pkg::ADDR_W-1:0] rd_addr,
    output logic                               rd_last,
    output logic                               tail_en,
    output logic                               busy,
    output logic                               done
);

    import cb_seq_ctrl_pkg::*;

    localparam int TCNT_W = (TAIL_CYCLES > 1) ? $clog2(TAIL_CYCLES) : 1;

    state_t              state_q;
    state_t              state_d;
    logic                size_q;
    logic                size_d;
    logic [TCNT_W-1:0]   tail_cnt_q;
    logic [TCNT_W-1:0]   tail_cnt_d;

    logic                cnt_clr;
    logic                cnt_en;
    logic [BCNT_W-1:0]   byte_cnt;
    logic [BCNT_W-1:0]   last_byte;
    logic [ADDR_W-1:0]   cnt_addr;
    logic                at_last;

    assign last_byte = last_byte_of(size_q, SMALL_BITS, LARGE_BITS);

    byte_step_counter u_byte_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .last_byte (last_byte),
        .cnt       (byte_cnt),
        .addr      (cnt_addr),
        .at_last   (at_last)
    );

    // Next-state, counter control and all outputs; abort overrides every
    // other transition and silences the strobes of its own cycle.
    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        tail_cnt_d = tail_cnt_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        rd_last    = 1'b0;
        tail_en    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    size_d  = block_size;
                    cnt_clr = 1'b1;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (abort) begin
                    cnt_clr    = 1'b1;
                    tail_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = cnt_addr;
                    if (at_last) begin
                        cnt_clr = 1'b1;
                        state_d = ST_ENCODE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end

            ST_ENCODE: begin
                busy = 1'b1;
                if (abort) begin
                    cnt_clr    = 1'b1;
                    tail_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = cnt_addr;
                    if (at_last) begin
                        rd_last    = 1'b1;
                        cnt_clr    = 1'b1;
                        tail_cnt_d = TCNT_W'(TAIL_CYCLES - 1);
                        state_d    = ST_TAIL;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end

            ST_TAIL: begin
                busy = 1'b1;
                if (abort) begin
                    cnt_clr    = 1'b1;
                    tail_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    tail_en = 1'b1;
                    if (tail_cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        tail_cnt_d = tail_cnt_q - TCNT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                busy    = 1'b1;
                state_d = ST_IDLE;
                if (abort) begin
                    cnt_clr    = 1'b1;
                    tail_cnt_d = '0;
                end else begin
                    done = 1'b1;
                end
            end

            default: begin
                cnt_clr    = 1'b1;
                tail_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State, latched block size and tail counter, synchronously reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            size_q     <= 1'b0;
            tail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            tail_cnt_q <= tail_cnt_d;
        end
    end

    // The byte counter must never run past the terminal byte of the block.
    always_ff @(posedge clk) begin
        if (!reset && busy) begin
            assert (byte_cnt <= last_byte);
        end
    end

endmodule

// File: doc/cb_seq_ctrl.md
Name: cb_seq_ctrl

Overview:
Sequences one turbo-encoder code block through three phases.
- LOAD: accepts input bytes into the block buffer.
- ENCODE: streams buffer read addresses to the encoder.
- TAIL: drives trellis-termination cycles, then signals completion.

Block length is 1056 bits (small) or 6144 bits (large). The buffer is addressed in bits, stepping 8 per byte. It sits between the input byte interface and the block buffer/encoder core, and owns the byte-granular block counter.

Parameters:
- SMALL_BITS, 1056, small code-block length in bits (must be a multiple of 8)
- LARGE_BITS, 6144, large code-block length in bits (must be a multiple of 8)
- TAIL_CYCLES, 4, number of trellis-termination cycles after the last read (≥1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a new block; honoured only in IDLE
- block_size  input  1  0 = small, 1 = large; sampled with start
- abort  input  1  abandon the current block; return to IDLE next cycle
- in_valid  input  1  input byte available
- in_ready  output  1  controller accepts a byte this cycle
- wr_en  output  1  buffer write strobe
- wr_addr  output  13  buffer bit address of the write, {byte_cnt,3'b000}
- rd_en  output  1  buffer read strobe to the encoder
- rd_addr  output  13  buffer bit address of the read, {byte_cnt,3'b000}
- rd_last  output  1  marks the final read of the block
- tail_en  output  1  encoder trellis-termination enable
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on block completion

Behaviour:
- States: IDLE, LOAD, ENCODE, TAIL, DONE. State and counters are registered.
- Reset: state = IDLE, byte_cnt = 0, tail_cnt = 0, size_q = 0. All outputs are 0 in the cycle after reset is sampled high. Reset in any state, mid-block included, discards the block; no done pulse is produced.
- Block length in bytes: last_byte = size_q ? LARGE_BITS/8-1 : SMALL_BITS/8-1, i.e. 767 or 131. byte_cnt is 10 bits.
- IDLE:
  - busy = 0, in_ready = 0.
  - On start = 1: latch size_q = block_size, clear byte_cnt, go to LOAD next cycle.
- LOAD:
  - in_ready = 1.
  - wr_en = in_valid & in_ready, combinational, same cycle as the handshake; wr_addr = {byte_cnt,3'b0}.
  - Each accepted byte increments byte_cnt.
  - A gap (in_valid = 0) holds byte_cnt, with wr_en = 0.
  - When the byte at byte_cnt == last_byte is accepted: clear byte_cnt, go to ENCODE.
- ENCODE:
  - rd_en = 1 every cycle; rd_addr = {byte_cnt,3'b0}; byte_cnt increments.
  - rd_last = 1 when byte_cnt == last_byte; that cycle transitions to TAIL and loads tail_cnt = TAIL_CYCLES-1.
  - in_ready = 0.
- TAIL:
  - tail_en = 1; tail_cnt decrements each cycle.
  - When tail_cnt == 0, go to DONE. Exactly TAIL_CYCLES cycles are spent in TAIL.
- DONE: done = 1 for one cycle, busy = 1, then IDLE.
- Latency with continuous in_valid and start in cycle 0:
  - LOAD occupies cycles 1..N, ENCODE N+1..2N, TAIL 2N+1..2N+T.
  - done is high in cycle 2N+T+1, where N = block bytes and T = TAIL_CYCLES.
- start outside IDLE is ignored; block_size is not re-sampled. start in the DONE cycle is ignored; it must be re-asserted in IDLE.
- abort (LOAD, ENCODE, TAIL or DONE):
  - Next state is IDLE and counters clear.
  - The abort cycle itself suppresses wr_en, rd_en, tail_en and done.
  - abort in IDLE has no effect. abort has priority over every other transition.
- Never wraps: byte_cnt cannot exceed last_byte, because the phase terminates on equality. Addresses stay ≤ 6136 (large) and ≤ 1048 (small).
- Outputs not driven by the current state are 0.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, ENCODE, TAIL, DONE); constants SMALL_BITS = 1056, LARGE_BITS = 6144, BYTE_SHIFT = 3, ADDR_W = 13, BCNT_W = 10.
- Sub-module byte_step_counter: 10-bit counter with sync clear, enable and terminal-compare against last_byte. It outputs cnt, addr = {cnt,3'b0} and at_last.
- The FSM and tail counter stay in cb_seq_ctrl.

Test Plan:
- Small block, in_valid held high, start at cycle 0:
  - wr_en in cycles 1..132, wr_addr 0,8,...,1048.
  - rd_en in cycles 133..264, rd_last at 264 with rd_addr 1048.
  - tail_en in cycles 265..268, done in cycle 269 only.
- Large block, same stimulus:
  - 768 writes, last wr_addr 6136.
  - rd_last in cycle 1536, done in cycle 1541.
  - busy is 0 in cycle 1542.
- Small block, in_valid toggled 1/0: write addresses stay contiguous 0..1048 with no repeats; byte_cnt holds during gaps; ENCODE begins the cycle after the 132nd accepted byte.
- start pulsed with block_size = 1 during ENCODE of a small block: ignored; block completes with 132 reads; the next block runs at the size sampled in IDLE.
- reset high at the 50th LOAD write: next cycle IDLE with all outputs 0; no done pulse; a following start runs a full block from wr_addr 0.
- abort in the 2nd TAIL cycle: tail_en is 0 that cycle; IDLE next cycle; done never pulses; busy drops.
